// File: rtl/serial_negator_pkg.sv
// Shared types and result function for the bit-serial two's-complement lanes.
// Combinational helper only; no timing or flow control lives here.
package serial_negator_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_e;

    // x must be zero above bit w-1; returns {ovf, y} with y in the low w bits.
    function automatic logic [MAX_W:0] neg_result(input logic [MAX_W-1:0] x,
                                                   input int              w,
                                                   input mode_e           mode);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] min_neg;
        logic [MAX_W-1:0] neg;
        logic [MAX_W-1:0] y;
        logic             ovf;
        mask    = {MAX_W{1'b1}} >> (MAX_W - w);
        min_neg = MAX_W'(1) << (w - 1);
        neg     = (~x + MAX_W'(1)) & mask;
        y       = x;
        ovf     = 1'b0;
        case (mode)
            MODE_NEG: begin
                y   = neg;
                ovf = (x == min_neg);
            end
            MODE_ABS: begin
                if ((x & min_neg) != '0) begin
                    y = neg;
                end
                ovf = (x == min_neg);
            end
            default: begin
                y   = x;
                ovf = 1'b0;
            end
        endcase
        return {ovf, y};
    endfunction

endpackage

// File: rtl/serial_negator_lane.sv
// One lane: capture shifter, pass/negate/abs compute, output shifter, parallel word + ovf.
// Result bit 0 registered on the completion edge; no backpressure, free-running output shift.
module serial_negator_lane
    import serial_negator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             sample,
    input  logic             complete,
    input  mode_e            mode,
    output logic             dout,
    output logic [WIDTH-1:0] pword,
    output logic             ovf
);

    logic [WIDTH-2:0] cap_q, cap_d;
    logic [WIDTH-2:0] out_q, out_d;
    logic             dout_q, dout_d;
    logic [WIDTH-1:0] pword_q, pword_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] x;
    logic [MAX_W:0]   res;

    // The live din is the MSB of the word on the completing edge.
    assign x   = {din, cap_q};
    assign res = neg_result(MAX_W'(x), WIDTH, mode);

    generate
        if (WIDTH < MAX_W) begin : g_unused
            logic unused_res_bits;
            assign unused_res_bits = ^res[MAX_W-1:WIDTH];
        end
    endgenerate

    always_comb begin
        cap_d   = cap_q;
        out_d   = out_q >> 1;
        dout_d  = out_q[0];
        pword_d = pword_q;
        ovf_d   = ovf_q;
        if (sample) begin
            cap_d = x[WIDTH-1:1];
        end
        if (complete) begin
            out_d   = res[WIDTH-1:1];
            dout_d  = res[0];
            pword_d = res[WIDTH-1:0];
            ovf_d   = res[MAX_W];
        end
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q   <= '0;
            out_q   <= '0;
            dout_q  <= 1'b0;
            pword_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            out_q   <= out_d;
            dout_q  <= dout_d;
            pword_q <= pword_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout  = dout_q;
    assign pword = pword_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/serial_negator.sv
// Multi-lane bit-serial pass/negate/abs unit framed by a shared start pulse.
// Result bit k emitted the cycle after input bit WIDTH-1+k is sampled; no backpressure.
module serial_negator
    import serial_negator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                   t_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [LANES-1:0]       din,
    output logic [LANES-1:0]       dout,
    output logic                   dout_valid,
    output logic                   dout_first,
    output logic [LANES*WIDTH-1:0] pword,
    output logic                   pword_valid,
    output logic [LANES-1:0]       ovf,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] emit_q, emit_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_first_q, dout_first_d;
    logic             pword_valid_q, pword_valid_d;
    logic             frame_err_q, frame_err_d;

    logic sample;
    logic complete;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        sample      = 1'b0;
        complete    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sample  = 1'b1;
                    mode_d  = mode_e'(mode);
                    cnt_d   = CNT_W'(1);
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sample = 1'b1;
                if (start) begin
                    // Early restart: the current bit becomes bit 0 of a new word.
                    frame_err_d = 1'b1;
                    mode_d      = mode_e'(mode);
                    cnt_d       = CNT_W'(1);
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Completions are at least WIDTH cycles apart, so a reload never cuts an emission short.
    always_comb begin
        emit_d        = emit_q;
        dout_valid_d  = 1'b0;
        dout_first_d  = 1'b0;
        pword_valid_d = complete;
        if (complete) begin
            dout_valid_d = 1'b1;
            dout_first_d = 1'b1;
            emit_d       = CNT_W'(WIDTH - 1);
        end else if (emit_q != '0) begin
            dout_valid_d = 1'b1;
            emit_d       = emit_q - CNT_W'(1);
        end
    end

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mode_q        <= MODE_PASS;
            emit_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_first_q  <= 1'b0;
            pword_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            emit_q        <= emit_d;
            dout_valid_q  <= dout_valid_d;
            dout_first_q  <= dout_first_d;
            pword_valid_q <= pword_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    generate
        for (genvar n = 0; n < LANES; n++) begin : g_lane
            serial_negator_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .t_clk    (t_clk),
                .rst_n    (rst_n),
                .din      (din[n]),
                .sample   (sample),
                .complete (complete),
                .mode     (mode_q),
                .dout     (dout[n]),
                .pword    (pword[n*WIDTH +: WIDTH]),
                .ovf      (ovf[n])
            );
        end
    endgenerate

    assign dout_valid  = dout_valid_q;
    assign dout_first  = dout_first_q;
    assign pword_valid = pword_valid_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_serial_negator.sv
// Directed bench for serial_negator with WIDTH=8, LANES=2.
module tb_serial_negator;

    localparam int W = 8;
    localparam int L = 2;

    logic           t_clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     mode  = 2'b00;
    logic [L-1:0]   din   = '0;
    logic [L-1:0]   dout;
    logic           dout_valid;
    logic           dout_first;
    logic [L*W-1:0] pword;
    logic           pword_valid;
    logic [L-1:0]   ovf;
    logic           frame_err;
    logic           busy;

    serial_negator #(
        .WIDTH (W),
        .LANES (L)
    ) dut (
        .t_clk       (t_clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_first  (dout_first),
        .pword       (pword),
        .pword_valid (pword_valid),
        .ovf         (ovf),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 t_clk = ~t_clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0, idx = 8, run = 0, max_run = 0, vcount = 0;
    int pvcount = 0, fecount = 0, last_start = 0, first_cyc = 0;
    int pv_prev = 0, pv_last = 0, act = 0;
    logic [7:0] rx0, rx1, done0, done1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then observe outputs 1ns later.
    task automatic step(input logic s, input logic [1:0] m, input logic [L-1:0] d);
        start = s;
        mode  = m;
        din   = d;
        @(posedge t_clk);
        #1;
        cyc++;
        if (s) last_start = cyc;
        if (dout_first) first_cyc = cyc;
        if (pword_valid) begin
            pvcount++;
            pv_prev = pv_last;
            pv_last = cyc;
        end
        if (frame_err) fecount++;
        if (dout_valid) begin
            if (dout_first) idx = 0;
            if (idx < 8) begin
                rx0[idx] = dout[0];
                rx1[idx] = dout[1];
                if (idx == 7) begin
                    done0 = rx0;
                    done1 = rx1;
                end
                idx++;
            end
            run++;
            vcount++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    endtask

    task automatic send_word(input logic [1:0] m, input logic [7:0] w0, input logic [7:0] w1);
        for (int i = 0; i < 8; i++) begin
            step(i == 0, m, {w1[i], w0[i]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 2'b00, 2'b00);
        end
    endtask

    task automatic clear_done();
        done0 = 'x;
        done1 = 'x;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},        dout,        0);
        check({tag, "_dout_valid"},  dout_valid,  0);
        check({tag, "_dout_first"},  dout_first,  0);
        check({tag, "_pword"},       pword,       0);
        check({tag, "_pword_valid"}, pword_valid, 0);
        check({tag, "_ovf"},         ovf,         0);
        check({tag, "_frame_err"},   frame_err,   0);
        check({tag, "_busy"},        busy,        0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge t_clk);
        rst_n = 1'b1;

        // 1: negate 0x05 / 0x00
        clear_done();
        send_word(2'b01, 8'h05, 8'h00);
        check("neg_pword_valid", pword_valid, 1);
        check("neg_dout_first", dout_first, 1);
        check("neg_pword", pword, 16'h00FB);
        check("neg_ovf", ovf, 2'b00);
        check("neg_latency", first_cyc - last_start, 7);
        check("neg_busy_after", busy, 0);
        idle(7);
        check("neg_serial0", done0, 8'hFB);
        check("neg_serial1", done1, 8'h00);
        idle(1);
        check("neg_valid_end", dout_valid, 0);
        check("neg_pword_hold", pword, 16'h00FB);

        // 2: abs with most-negative input, reserved mode, negate of most-negative
        clear_done();
        send_word(2'b10, 8'hF6, 8'h80);
        check("abs_pword", pword, 16'h800A);
        check("abs_ovf", ovf, 2'b10);
        idle(8);
        check("abs_serial0", done0, 8'h0A);
        check("abs_serial1", done1, 8'h80);
        clear_done();
        send_word(2'b11, 8'h3C, 8'h3C);
        check("rsvd_pword", pword, 16'h3C3C);
        check("rsvd_ovf", ovf, 2'b00);
        idle(8);
        check("rsvd_serial0", done0, 8'h3C);
        send_word(2'b01, 8'h80, 8'h7F);
        check("negmin_pword", pword, 16'h8180);
        check("negmin_ovf", ovf, 2'b01);
        idle(8);

        // 3: back-to-back words
        vcount = 0; max_run = 0; pvcount = 0;
        clear_done();
        send_word(2'b01, 8'h01, 8'h01);
        check("b2b_pword1", pword, 16'hFFFF);
        send_word(2'b00, 8'h3C, 8'h3C);
        check("b2b_serial_w1_0", done0, 8'hFF);
        check("b2b_serial_w1_1", done1, 8'hFF);
        check("b2b_pword2", pword, 16'h3C3C);
        idle(8);
        check("b2b_serial_w2_0", done0, 8'h3C);
        check("b2b_valid_cycles", vcount, 16);
        check("b2b_valid_run", max_run, 16);
        check("b2b_pv_count", pvcount, 2);
        check("b2b_pv_spacing", pv_last - pv_prev, 8);

        // 4: early restart after 3 bits
        pvcount = 0; fecount = 0;
        clear_done();
        step(1'b1, 2'b01, 2'b11);
        check("abort_busy", busy, 1);
        step(1'b0, 2'b01, 2'b11);
        step(1'b0, 2'b01, 2'b11);
        check("abort_no_fe_yet", fecount, 0);
        send_word(2'b01, 8'h7F, 8'h7F);
        check("abort_fe_cycles", fecount, 1);
        check("abort_pv_count", pvcount, 1);
        check("abort_pword", pword, 16'h8181);
        check("abort_latency", first_cyc - last_start, 7);
        idle(8);
        check("abort_serial0", done0, 8'h81);
        check("abort_serial1", done1, 8'h81);

        // 5: reset during the 4th emitted bit
        send_word(2'b01, 8'h05, 8'h00);
        idle(3);
        check("rstmid_valid", dout_valid, 1);
        check("rstmid_bit3", dout, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        @(posedge t_clk);
        #1;
        rst_n = 1'b1;
        vcount = 0; pvcount = 0;
        idle(10);
        check("rstmid_no_valid", vcount, 0);
        check("rstmid_no_pv", pvcount, 0);
        send_word(2'b00, 8'h55, 8'hAA);
        check("rstmid_new_pv", pvcount, 1);
        check("rstmid_new_pword", pword, 16'hAA55);
        idle(8);

        // 6: din toggling with start low
        act = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b01, 2'(i));
            if (busy || dout_valid || pword_valid) act++;
        end
        check("idle_activity", act, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog timeout");
    end

endmodule
